// File: rtl/mem_if_pkg.sv
// Shared definitions for the mem_request/mem_ready interface:
// access-width codes, the byte-count helper and the responder state encoding.
package mem_if_pkg;

    localparam logic [1:0] MEM_ACC_8  = 2'b00;
    localparam logic [1:0] MEM_ACC_16 = 2'b01;
    localparam logic [1:0] MEM_ACC_32 = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        READY  = 2'd3
    } state_t;

    // Bytes moved by an access: 1/2/4 by code, never more than the bus carries.
    // The unused code 2'b11 falls into the 1-byte case.
    function automatic logic [2:0] acc_bytes(input logic [1:0] width_code, input int m_width);
        int n;
        int lanes;
        case (width_code)
            MEM_ACC_16: n = 2;
            MEM_ACC_32: n = 4;
            default:    n = 1;
        endcase
        lanes = m_width / 8;
        if (n > lanes) n = lanes;
        return 3'(n);
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Byte-wide single-port RAM: synchronous write, combinational read, no reset.
module mem_byte_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // Store one byte on a write-enabled edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches one request, moves one byte per cycle
// through a byte RAM (little-endian, wrapping addresses), optionally stalls,
// then holds mem_ready until the initiator releases mem_request.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int         M_WIDTH     = 8,
    parameter int         DEPTH       = 256,
    parameter int         WAIT_CYCLES = 0,
    parameter logic [1:0] MEM_ACC_8   = 2'b00,
    parameter logic [1:0] MEM_ACC_16  = 2'b01,
    parameter logic [1:0] MEM_ACC_32  = 2'b10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_request,
    input  logic [M_WIDTH-1:0] mem_addr,
    input  logic [1:0]         mem_data_width,
    input  logic               mem_we_in,
    input  logic [M_WIDTH-1:0] mem_data_in,
    output logic [M_WIDTH-1:0] mem_data_out,
    output logic               mem_ready
);

    localparam int AW  = $clog2(DEPTH);
    localparam int NB  = M_WIDTH / 8;
    // Byte lanes an access can touch: the bus width, capped at a 32-bit access.
    localparam int NL  = (NB < 4) ? NB : 4;
    localparam int WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             state;
    logic [M_WIDTH-1:0] addr_q;
    logic [M_WIDTH-1:0] wdata_q;
    logic [2:0]         nbytes_q;
    logic               we_q;
    logic [2:0]         cnt;
    logic [WCW-1:0]     wcnt;

    logic [1:0]         canon_code;
    logic [AW-1:0]      ram_addr;
    logic               ram_we;
    logic [7:0]         ram_wdata;
    logic [7:0]         ram_rdata;
    logic               last_beat;
    logic               last_wait;

    // Map this instance's width codes onto the package encoding; unknown codes are 1-byte.
    always_comb begin
        canon_code = mem_if_pkg::MEM_ACC_8;
        if (mem_data_width == MEM_ACC_32)      canon_code = mem_if_pkg::MEM_ACC_32;
        else if (mem_data_width == MEM_ACC_16) canon_code = mem_if_pkg::MEM_ACC_16;
        else if (mem_data_width == MEM_ACC_8)  canon_code = mem_if_pkg::MEM_ACC_8;
    end

    // Select the write-data byte for the current beat.
    always_comb begin
        ram_wdata = 8'h00;
        for (int k = 0; k < NL; k++) begin
            if (cnt == 3'(k)) ram_wdata = wdata_q[8*k +: 8];
        end
    end

    // Truncation to AW bits makes the byte address wrap modulo DEPTH.
    assign ram_addr  = AW'(addr_q + M_WIDTH'(cnt));
    // Reset blocks the write at its own edge so an abandoned access stops cleanly.
    assign ram_we    = (state == ACCESS) && we_q && !rst;
    assign last_beat = (cnt == nbytes_q - 3'd1);
    assign last_wait = (wcnt == WLAST);

    mem_byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Access sequencer: accept, byte beats, optional stall, ready handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mem_ready    <= 1'b0;
            mem_data_out <= '0;
            cnt          <= '0;
            wcnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_request) begin
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_data_in;
                        we_q     <= mem_we_in;
                        nbytes_q <= acc_bytes(canon_code, M_WIDTH);
                        cnt      <= '0;
                        if (!mem_we_in) mem_data_out <= '0;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        for (int k = 0; k < NL; k++) begin
                            if (cnt == 3'(k)) mem_data_out[8*k +: 8] <= ram_rdata;
                        end
                    end
                    cnt <= cnt + 3'd1;
                    if (last_beat) begin
                        if (WAIT_CYCLES > 0) begin
                            wcnt  <= '0;
                            state <= WAIT;
                        end else if (mem_request) begin
                            mem_ready <= 1'b1;
                            state     <= READY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                WAIT: begin
                    wcnt <= wcnt + 1'b1;
                    if (last_wait) begin
                        if (mem_request) begin
                            mem_ready <= 1'b1;
                            state     <= READY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                READY: begin
                    if (!mem_request) begin
                        mem_ready <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side end of the mem_request/mem_ready interface; sits behind the memory mux and serves the access the mux forwards.
- Byte-organised RAM, one byte moved per cycle, so 8/16/32-bit accesses take 1/2/4 beat cycles.
- Read data is assembled little-endian. mem_ready is held until the initiator drops mem_request.

Parameters:
- M_WIDTH, 8, address and data bus width; must be a multiple of 8.
- DEPTH, 256, RAM size in bytes; power of two, at most 2^M_WIDTH.
- WAIT_CYCLES, 0, extra stall cycles inserted after the last byte beat, before mem_ready.
- MEM_ACC_8, 2'b00, access-width code for 1 byte.
- MEM_ACC_16, 2'b01, access-width code for 2 bytes.
- MEM_ACC_32, 2'b10, access-width code for 4 bytes.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- mem_request  in  1  access request from the initiator.
- mem_addr  in  M_WIDTH  byte address of the first byte.
- mem_data_width  in  2  access-width code.
- mem_we_in  in  1  1 = write, 0 = read.
- mem_data_in  in  M_WIDTH  write data; byte k is bits [8k+7:8k].
- mem_data_out  out  M_WIDTH  read data returned to the initiator.
- mem_ready  out  1  access complete; data valid.

Behaviour:
- Reset, with rst high at an edge:
  - state=IDLE; mem_ready=0; mem_data_out=0; byte counter=0; wait counter=0.
  - RAM contents are not cleared.
  - Reset mid-access abandons the access; bytes already written stay written.
- Byte count N: 1/2/4 for MEM_ACC_8/16/32, then clamped to M_WIDTH/8. Code 2'b11 is treated as MEM_ACC_8.
- Byte k of an access targets RAM[(mem_addr + k) mod DEPTH]. Address bits above log2(DEPTH) are ignored, so addresses wrap.
- IDLE:
  - Edge with mem_request=1: latch addr, width, we and write data into internal registers; cnt=0; go to ACCESS.
  - If the access is a read, clear mem_data_out to 0 at this edge so unused upper bytes read as zero.
  - Port inputs are ignored after latching.
- ACCESS, one byte per edge:
  - Write: RAM[addr+cnt] <= data byte cnt.
  - Read: mem_data_out byte cnt <= RAM[addr+cnt]. RAM read is combinational (array read), so there is no extra read latency.
  - cnt increments each edge.
  - After beat N-1: go to WAIT if WAIT_CYCLES>0, else to READY with mem_ready<=1 at that same edge.
- WAIT: count WAIT_CYCLES edges, then go to READY with mem_ready<=1.
- Latency: mem_ready is first high N+WAIT_CYCLES cycles after the accepting edge.
  - 8-bit access, WAIT_CYCLES=0: ready is high in the cycle after the accepting edge.
- READY:
  - mem_ready=1; mem_data_out held stable.
  - Edge with mem_request=1: stay in READY.
  - Edge with mem_request=0: mem_ready<=0, go to IDLE.
  - A new request is therefore only accepted after at least one low-request cycle. This matches the mux, which always drops mem_request for one cycle before it re-arbitrates.
- Request dropped during ACCESS/WAIT (protocol violation):
  - The access still completes fully; writes are committed.
  - On completion, if mem_request=0, go straight to IDLE without pulsing mem_ready.
- mem_ready is a registered output, never combinational from mem_request.
- mem_data_out keeps its last value in IDLE until the next read is accepted.

Decomposition:
- Shared package mem_if_pkg:
  - MEM_ACC_8/16/32 codes.
  - Function acc_bytes(width_code, M_WIDTH), which returns the clamped N.
  - State encoding IDLE/ACCESS/WAIT/READY.
- Sub-module mem_byte_ram: single-port DEPTH x 8 array, synchronous write enable, combinational read, no reset.

Test Plan:
- MEM_ACC_8 write of 0xA5 to 0x10, release, then read 0x10 -> mem_ready is high 1 cycle after accept each time; read returns mem_data_out=0xA5.
- M_WIDTH=32: MEM_ACC_32 write of 0xDEADBEEF at 0x20, then MEM_ACC_16 read at 0x20 -> RAM[0x20..0x23]=EF,BE,AD,DE; read returns 0x0000BEEF; ready latency is 4 then 2.
- M_WIDTH=32, DEPTH=256: MEM_ACC_32 write of 0x11223344 at 0xFE -> bytes land at 0xFE, 0xFF, 0x00, 0x01 (44, 33, 22, 11), confirming wrap-around.
- M_WIDTH=8: MEM_ACC_32 and code 2'b11 each behave as a 1-byte access with 1-cycle latency.
- WAIT_CYCLES=2: hold mem_request 5 cycles past ready -> mem_ready stays 1 and data stays stable; a request drop gives ready=0 next edge; re-request after a 1-cycle gap is accepted.
- Assert rst during beat 2 of a 4-byte write -> next cycle mem_ready=0 and state=IDLE; bytes 0..1 are written, bytes 2..3 keep their old values. Also drop mem_request mid-access -> access completes and mem_ready never pulses.
